// File: rtl/sequenciador_pkg.sv
// Shared types and constants for the LED sequence playback controller.
// State codes double as the debug display encoding.
package sequenciador_pkg;

   typedef enum logic [2:0] {
      OCIOSO  = 3'd0,
      LEITURA = 3'd1,
      ACESO   = 3'd2,
      APAGADO = 3'd3,
      FIM     = 3'd4
   } estado_t;

   localparam int T_ON_LENTO_DEF   = 1000;
   localparam int T_OFF_LENTO_DEF  = 500;
   localparam int T_ON_RAPIDO_DEF  = 500;
   localparam int T_OFF_RAPIDO_DEF = 250;
   localparam int TW_DEF           = 11;

   localparam logic [2:0] NOTA_NENHUMA = 3'd7;

   // Lowest set bit wins when the colour is not one-hot.
   function automatic logic [2:0] indice_nota(input logic [6:0] cor);
      logic [2:0] idx;
      idx = NOTA_NENHUMA;
      for (int i = 6; i >= 0; i--) begin
         if (cor[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sequenciador_leds_if.sv
// Control, memory and display bundle of the playback controller.
// The slave side is the controller; the master side is its environment.
interface sequenciador_leds_if;

   logic       iniciar;
   logic       abortar;
   logic       nivel;
   logic [3:0] limite;
   logic [6:0] mem_dado;
   logic [3:0] mem_endereco;
   logic [6:0] leds;
   logic       nota_valida;
   logic [2:0] nota_codigo;
   logic       ocupado;
   logic       pronto;
   logic [2:0] db_estado;

   modport slave (
      input  iniciar, abortar, nivel, limite, mem_dado,
      output mem_endereco, leds, nota_valida, nota_codigo,
      output ocupado, pronto, db_estado
   );

   modport master (
      output iniciar, abortar, nivel, limite, mem_dado,
      input  mem_endereco, leds, nota_valida, nota_codigo,
      input  ocupado, pronto, db_estado
   );

endinterface

// File: rtl/sequenciador_leds_contador_ticks.sv
// Up counter for on/off phase timing with a runtime terminal value.
// Clear takes priority over enable.
module contador_ticks #(
   parameter int TW = 11
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          limpar,
   input  logic          habilitar,
   input  logic [TW-1:0] limite,
   output logic [TW-1:0] valor,
   output logic          terminal
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valor <= '0;
      end else if (limpar) begin
         valor <= '0;
      end else if (habilitar) begin
         valor <= valor + 1'b1;
      end
   end

   assign terminal = (valor == limite);

endmodule

// File: rtl/sequenciador_leds.sv
// Plays memory colours 0..limite on the LEDs with on/off timing,
// emitting a note strobe and code per lit slot.
module sequenciador_leds
   import sequenciador_pkg::*;
#(
   parameter int T_ON_LENTO   = T_ON_LENTO_DEF,
   parameter int T_OFF_LENTO  = T_OFF_LENTO_DEF,
   parameter int T_ON_RAPIDO  = T_ON_RAPIDO_DEF,
   parameter int T_OFF_RAPIDO = T_OFF_RAPIDO_DEF,
   parameter int TW           = TW_DEF
) (
   input  logic                 clock,
   input  logic                 reset,
   sequenciador_leds_if.slave   bus
);

   estado_t       estado, estado_d;
   logic [3:0]    endereco, endereco_d;
   logic [3:0]    limite_reg;
   logic          nivel_reg;
   logic [6:0]    led_reg;
   logic          limpar;
   logic          habilitar;
   logic [TW-1:0] lim_sel;
   logic [TW-1:0] lim_on;
   logic [TW-1:0] lim_off;
   logic [TW-1:0] tempo;
   logic          terminal;

   assign lim_on  = nivel_reg ? TW'(T_ON_RAPIDO - 1)
                              : TW'(T_ON_LENTO - 1);
   assign lim_off = nivel_reg ? TW'(T_OFF_RAPIDO - 1)
                              : TW'(T_OFF_LENTO - 1);

   contador_ticks #(.TW(TW)) u_ticks (
      .clock     (clock),
      .reset     (reset),
      .limpar    (limpar),
      .habilitar (habilitar),
      .limite    (lim_sel),
      .valor     (tempo),
      .terminal  (terminal)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado   <= OCIOSO;
         endereco <= '0;
      end else begin
         estado   <= estado_d;
         endereco <= endereco_d;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         limite_reg <= '0;
         nivel_reg  <= 1'b0;
         led_reg    <= '0;
      end else begin
         if (estado == OCIOSO && bus.iniciar) begin
            limite_reg <= bus.limite;
            nivel_reg  <= bus.nivel;
         end
         if (estado == LEITURA) led_reg <= bus.mem_dado;
      end
   end

   always_comb begin
      estado_d   = estado;
      endereco_d = endereco;
      limpar     = 1'b0;
      habilitar  = 1'b0;
      lim_sel    = lim_on;
      case (estado)
         OCIOSO: begin
            endereco_d = '0;
            if (bus.iniciar) estado_d = LEITURA;
         end
         LEITURA: begin
            limpar   = 1'b1;
            estado_d = ACESO;
         end
         ACESO: begin
            habilitar = 1'b1;
            if (terminal) begin
               limpar   = 1'b1;
               estado_d = APAGADO;
            end
         end
         APAGADO: begin
            habilitar = 1'b1;
            lim_sel   = lim_off;
            if (terminal) begin
               limpar = 1'b1;
               if (endereco == limite_reg) begin
                  estado_d   = FIM;
                  endereco_d = '0;
               end else begin
                  estado_d   = LEITURA;
                  endereco_d = endereco + 1'b1;
               end
            end
         end
         FIM: begin
            estado_d   = OCIOSO;
            endereco_d = '0;
         end
         default: begin
            estado_d   = OCIOSO;
            endereco_d = '0;
         end
      endcase
      if (bus.abortar && estado != OCIOSO) begin
         estado_d   = OCIOSO;
         endereco_d = '0;
         limpar     = 1'b1;
      end
   end

   // Present the next address so the 1-cycle ROM data lands in LEITURA.
   assign bus.mem_endereco = endereco_d;

   assign bus.leds        = (estado == ACESO) ? led_reg : 7'd0;
   assign bus.nota_valida = (estado == ACESO) && (tempo == '0)
                            && (led_reg != 7'd0);
   assign bus.nota_codigo = indice_nota(bus.leds);
   assign bus.ocupado     = (estado != OCIOSO);
   assign bus.pronto      = (estado == FIM);
   assign bus.db_estado   = estado;

endmodule

// File: tb/tb_sequenciador_leds.sv
// Directed bench for sequenciador_leds with short on/off times.
// Sync ROM model feeds mem_dado one cycle after mem_endereco.
module tb_sequenciador_leds;

   logic clock;
   logic reset;
   int   checks;
   int   failures;

   logic [6:0] rom [16];

   sequenciador_leds_if bus ();

   sequenciador_leds #(
      .T_ON_LENTO   (4),
      .T_OFF_LENTO  (2),
      .T_ON_RAPIDO  (2),
      .T_OFF_RAPIDO (1),
      .TW           (11)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always_ff @(posedge clock) bus.mem_dado <= rom[bus.mem_endereco];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [3:0] lim, input logic niv);
      bus.limite  = lim;
      bus.nivel   = niv;
      bus.iniciar = 1'b1;
      step();
      bus.iniciar = 1'b0;
   endtask

   // Entered in LEITURA; leaves one cycle after the last APAGADO cycle.
   task automatic play_note(input logic [3:0] a, input logic [6:0] c,
                            input logic [2:0] code, input int ton,
                            input int toff);
      chk("leit_estado", 32'(bus.db_estado), 1);
      chk("leit_endereco", 32'(bus.mem_endereco), 32'(a));
      chk("leit_leds", 32'(bus.leds), 0);
      for (int i = 0; i < ton; i++) begin
         step();
         chk("aceso_estado", 32'(bus.db_estado), 2);
         chk("aceso_leds", 32'(bus.leds), 32'(c));
         chk("nota_valida", 32'(bus.nota_valida),
             (i == 0 && c != 7'd0) ? 1 : 0);
         chk("nota_codigo", 32'(bus.nota_codigo), 32'(code));
      end
      for (int j = 0; j < toff; j++) begin
         step();
         chk("apagado_estado", 32'(bus.db_estado), 3);
         chk("apagado_leds", 32'(bus.leds), 0);
         chk("apagado_codigo", 32'(bus.nota_codigo), 7);
      end
      step();
   endtask

   task automatic check_fim();
      chk("fim_estado", 32'(bus.db_estado), 4);
      chk("fim_pronto", 32'(bus.pronto), 1);
      step();
      chk("pos_fim_estado", 32'(bus.db_estado), 0);
      chk("pos_fim_pronto", 32'(bus.pronto), 0);
      chk("pos_fim_ocupado", 32'(bus.ocupado), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks      = 0;
      failures    = 0;
      reset       = 1'b1;
      bus.iniciar = 1'b0;
      bus.abortar = 1'b0;
      bus.nivel   = 1'b0;
      bus.limite  = 4'd0;
      for (int i = 0; i < 16; i++) rom[i] = 7'd0;
      rom[0] = 7'h01;
      rom[1] = 7'h04;
      rom[2] = 7'h40;
      repeat (3) step();
      reset = 1'b0;
      step();

      // 1: reset / idle
      chk("rst_leds", 32'(bus.leds), 0);
      chk("rst_ocupado", 32'(bus.ocupado), 0);
      chk("rst_pronto", 32'(bus.pronto), 0);
      chk("rst_codigo", 32'(bus.nota_codigo), 7);
      chk("rst_estado", 32'(bus.db_estado), 0);
      chk("rst_endereco", 32'(bus.mem_endereco), 0);
      step();
      chk("idle_estado", 32'(bus.db_estado), 0);

      // 2: three notes, pronto 21 cycles after LEITURA entry
      start(4'd2, 1'b0);
      chk("t2_ocupado", 32'(bus.ocupado), 1);
      play_note(4'd0, 7'h01, 3'd0, 4, 2);
      play_note(4'd1, 7'h04, 3'd2, 4, 2);
      play_note(4'd2, 7'h40, 3'd6, 4, 2);
      check_fim();

      // 3: full 16-entry run, no wrap
      for (int i = 0; i < 16; i++) rom[i] = 7'(1 << (i % 7));
      start(4'd15, 1'b0);
      for (int i = 0; i < 16; i++) begin
         play_note(4'(i), 7'(1 << (i % 7)), 3'(i % 7), 4, 2);
      end
      check_fim();

      // 4: abort during ACESO of address 1, then restart
      rom[0] = 7'h01;
      rom[1] = 7'h04;
      rom[2] = 7'h40;
      start(4'd2, 1'b0);
      play_note(4'd0, 7'h01, 3'd0, 4, 2);
      step();
      step();
      chk("t4_aceso", 32'(bus.db_estado), 2);
      bus.abortar = 1'b1;
      step();
      bus.abortar = 1'b0;
      chk("ab_estado", 32'(bus.db_estado), 0);
      chk("ab_leds", 32'(bus.leds), 0);
      chk("ab_ocupado", 32'(bus.ocupado), 0);
      chk("ab_endereco", 32'(bus.mem_endereco), 0);
      for (int i = 0; i < 10; i++) begin
         chk("ab_sem_pronto", 32'(bus.pronto), 0);
         step();
      end
      start(4'd0, 1'b0);
      play_note(4'd0, 7'h01, 3'd0, 4, 2);
      check_fim();

      // 5: fast level, mid-run changes ignored
      start(4'd1, 1'b1);
      bus.nivel   = 1'b0;
      bus.limite  = 4'd3;
      bus.iniciar = 1'b1;
      play_note(4'd0, 7'h01, 3'd0, 2, 1);
      bus.iniciar = 1'b0;
      play_note(4'd1, 7'h04, 3'd2, 2, 1);
      check_fim();

      // 6: dark slot at address 1
      rom[1] = 7'h00;
      start(4'd2, 1'b0);
      play_note(4'd0, 7'h01, 3'd0, 4, 2);
      play_note(4'd1, 7'h00, 3'd7, 4, 2);
      play_note(4'd2, 7'h40, 3'd6, 4, 2);
      check_fim();

      // iniciar with abortar in idle still starts; then async reset
      bus.abortar = 1'b1;
      start(4'd2, 1'b0);
      bus.abortar = 1'b0;
      chk("ini_ab_estado", 32'(bus.db_estado), 1);
      repeat (5) step();
      chk("pre_rst_estado", 32'(bus.db_estado), 3);
      reset = 1'b1;
      #1;
      chk("arst_estado", 32'(bus.db_estado), 0);
      chk("arst_leds", 32'(bus.leds), 0);
      chk("arst_ocupado", 32'(bus.ocupado), 0);
      chk("arst_codigo", 32'(bus.nota_codigo), 7);
      chk("arst_endereco", 32'(bus.mem_endereco), 0);
      step();
      reset = 1'b0;
      step();
      chk("pos_rst_estado", 32'(bus.db_estado), 0);
      chk("pos_rst_pronto", 32'(bus.pronto), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
